// File: rtl/alu_operand_regfile_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_regfile_if
//  Description : Bundle of the operand register file bus. It holds the two
//                asynchronous read ports, the ALU result write port with its
//                flag capture strobe, the external/immediate load port, and
//                the registered status flags.
//                  master : the CPU control/ALU side. It drives addresses,
//                           write data and enables, and receives operands and
//                           flags.
//                  slave  : the register file itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_operand_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);

  // Operand read ports (combinational, zero latency)
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;

  // ALU result write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // External / immediate load port
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;

  // Status flag capture and outputs
  logic              flag_we;
  logic              carry_in;
  logic              flag_c;
  logic              flag_z;
  logic              flag_n;

  modport master (
    output rd_addr_a,
    input  rd_data_a,
    output rd_addr_b,
    input  rd_data_b,
    output wr_en,
    output wr_addr,
    output wr_data,
    output ld_en,
    output ld_addr,
    output ld_data,
    output flag_we,
    output carry_in,
    input  flag_c,
    input  flag_z,
    input  flag_n
  );

  modport slave (
    input  rd_addr_a,
    output rd_data_a,
    input  rd_addr_b,
    output rd_data_b,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  ld_en,
    input  ld_addr,
    input  ld_data,
    input  flag_we,
    input  carry_in,
    output flag_c,
    output flag_z,
    output flag_n
  );

endinterface
`default_nettype wire

// File: rtl/alu_operand_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_regfile
//  Description : Operand register file and status-flag register for the 8-bit
//                ALU datapath. Two combinational read ports feed the ALU
//                operands. The ALU result is written back through one write
//                port, and a second port loads external or immediate data.
//                The carry flag is captured from the ALU, and the zero and
//                negative flags are derived from the result.
//  Ports       : clk        - system clock, rising-edge active
//                rst_n      - asynchronous active-low reset
//                bus.slave  - read ports A/B, result write port, load port,
//                             flag capture strobe/carry input, flag outputs
//  Parameters  : DATA_W     - register / data width
//                ADDR_W     - register address width
//                NUM_REGS   - implemented registers (<= 2**ADDR_W)
//                DATA_W and ADDR_W must match the bound interface instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_operand_regfile #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  alu_operand_regfile_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] reg_q [NUM_REGS];
  logic [DATA_W-1:0] reg_d [NUM_REGS];

  logic              flag_c_q;
  logic              flag_z_q;
  logic              flag_n_q;
  logic              flag_c_d;
  logic              flag_z_d;
  logic              flag_n_d;

  // One-hot write selects per port. An address at or above NUM_REGS matches
  // no register, so the write is ignored and has no side effects.
  logic [NUM_REGS-1:0] wr_sel;
  logic [NUM_REGS-1:0] ld_sel;

  logic [DATA_W-1:0] rd_data_a_w;
  logic [DATA_W-1:0] rd_data_b_w;

  // --------------------------------------------------------------------------
  // Write address decode
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    assign wr_sel[gi] = bus.wr_en && (bus.wr_addr == ADDR_W'(gi));
    assign ld_sel[gi] = bus.ld_en && (bus.ld_addr == ADDR_W'(gi));
  end

  // --------------------------------------------------------------------------
  // Register next state. The load port takes priority over the result port
  // when both target the same register.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_d[i] = reg_q[i];
      if (ld_sel[i]) begin
        reg_d[i] = bus.ld_data;
      end else if (wr_sel[i]) begin
        reg_d[i] = bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_q[i] <= reg_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Status flags. These are taken from wr_data whether or not wr_en is set,
  // so that compare-style operations update the flags without a writeback.
  // --------------------------------------------------------------------------
  always_comb begin
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    if (bus.flag_we) begin
      flag_c_d = bus.carry_in;
      flag_z_d = (bus.wr_data == '0);
      flag_n_d = bus.wr_data[DATA_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports. These read only the stored contents and have no bypass from
  // the write ports. A bypass would close a combinational loop through the
  // ALU (rd_data -> ALU -> wr_data). An out-of-range address reads 0.
  // --------------------------------------------------------------------------
  always_comb begin
    rd_data_a_w = '0;
    rd_data_b_w = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr_a == ADDR_W'(i)) begin
        rd_data_a_w = reg_q[i];
      end
      if (bus.rd_addr_b == ADDR_W'(i)) begin
        rd_data_b_w = reg_q[i];
      end
    end
  end

  assign bus.rd_data_a = rd_data_a_w;
  assign bus.rd_data_b = rd_data_b_w;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_regfile
//  Description : Scoreboard bench for alu_operand_regfile. The stimulus
//                process sets the read addresses and pushes the expected
//                operands and flags. The monitor pops and compares them on
//                the falling edge, where the DUT outputs are stable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_operand_regfile;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  logic clk;
  logic rst_n;

  alu_operand_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  alu_operand_regfile #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              ca;
    logic [ADDR_W-1:0] aa;
    logic [DATA_W-1:0] ea;
    logic              cb;
    logic [ADDR_W-1:0] ab;
    logic [DATA_W-1:0] eb;
    logic [2:0]        ef;   // {C, Z, N}
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    checks   = 0;
  int    failures = 0;

  // Monitor: compare every pending expectation against the DUT outputs.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (e.ca) begin
          checks++;
          if (bus.rd_data_a !== e.ea) begin
            failures++;
            $display("FAIL %s rd_data_a[R%0d] got=%h exp=%h", nm, e.aa, bus.rd_data_a, e.ea);
          end
        end
        if (e.cb) begin
          checks++;
          if (bus.rd_data_b !== e.eb) begin
            failures++;
            $display("FAIL %s rd_data_b[R%0d] got=%h exp=%h", nm, e.ab, bus.rd_data_b, e.eb);
          end
        end
        checks++;
        if ({bus.flag_c, bus.flag_z, bus.flag_n} !== e.ef) begin
          failures++;
          $display("FAIL %s flags(CZN) got=%b exp=%b", nm,
                   {bus.flag_c, bus.flag_z, bus.flag_n}, e.ef);
        end
      end
    end
  end

  // Set the read addresses and queue the expectation. The monitor samples on
  // the next falling edge. Then advance to just past the following rising
  // edge, so any enables set by the caller take effect on that edge.
  task automatic check(input string nm,
                       input logic [ADDR_W-1:0] aa, input logic ca, input logic [DATA_W-1:0] ea,
                       input logic [ADDR_W-1:0] ab, input logic cb, input logic [DATA_W-1:0] eb,
                       input logic [2:0] ef);
    exp_t e;
    bus.rd_addr_a = aa;
    bus.rd_addr_b = ab;
    e.ca = ca; e.aa = aa; e.ea = ea;
    e.cb = cb; e.ab = ab; e.eb = eb;
    e.ef = ef;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DATA_W-1:0] model [NUM_REGS];
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;

  initial begin
    rst_n         = 1'b1;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.ld_en     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    bus.flag_we   = 1'b0;
    bus.carry_in  = 1'b0;

    // ---- 1. Reset asserted between edges, then read-back ----------------
    step();
    #1 rst_n = 1'b0;
    for (int i = 0; i < NUM_REGS / 2; i++) begin
      check("rst_read", ADDR_W'(2*i), 1'b1, 8'h00, ADDR_W'(2*i+1), 1'b1, 8'h00, 3'b000);
    end
    rst_n = 1'b1;
    bus.ld_en = 1'b1; bus.ld_addr = 3'd1; bus.ld_data = 8'h6F;
    step();
    bus.ld_addr = 3'd2;
    step();
    bus.ld_en = 1'b0;
    check("load_r1_r2", 3'd1, 1'b1, 8'h6F, 3'd2, 1'b1, 8'h6F, 3'b000);

    // ---- 2. Result writeback with flags, then compare-only --------------
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 8'hDE;
    bus.flag_we = 1'b1; bus.carry_in = 1'b0;
    step();
    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.carry_in = 1'b1;  // flag_we still 1
    check("wb_r3_flags", 3'd3, 1'b1, 8'hDE, 3'd1, 1'b1, 8'h6F, 3'b001);
    bus.flag_we = 1'b0;
    check("cmp_flags", 3'd3, 1'b1, 8'hDE, 3'd2, 1'b1, 8'h6F, 3'b110);

    // ---- 3. No write-to-read bypass -------------------------------------
    bus.ld_en = 1'b1; bus.ld_addr = 3'd4; bus.ld_data = 8'h11;
    step();
    bus.ld_en = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd4; bus.wr_data = 8'h22;
    check("nobypass_pre", 3'd4, 1'b1, 8'h11, 3'd4, 1'b1, 8'h11, 3'b110);
    bus.wr_en = 1'b0;
    check("nobypass_post", 3'd4, 1'b1, 8'h22, 3'd3, 1'b1, 8'hDE, 3'b110);

    // ---- 4. Write-port collision, then disjoint dual write --------------
    bus.ld_en = 1'b1; bus.ld_addr = 3'd5; bus.ld_data = 8'hAA;
    bus.wr_en = 1'b1; bus.wr_addr = 3'd5; bus.wr_data = 8'h55;
    step();
    bus.ld_en = 1'b0; bus.wr_en = 1'b0;
    check("collide_ld_wins", 3'd5, 1'b1, 8'hAA, 3'd6, 1'b1, 8'h00, 3'b110);
    bus.ld_en = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 3'd6;
    step();
    bus.ld_en = 1'b0; bus.wr_en = 1'b0;
    check("dual_write", 3'd5, 1'b1, 8'hAA, 3'd6, 1'b1, 8'h55, 3'b110);

    // ---- 5. Reset mid-operation -----------------------------------------
    bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 8'hFF;
    bus.flag_we = 1'b1; bus.carry_in = 1'b1;
    step();
    bus.wr_en = 1'b0; bus.flag_we = 1'b0;
    check("r7_ff", 3'd7, 1'b1, 8'hFF, 3'd4, 1'b1, 8'h22, 3'b101);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd7; bus.wr_data = 8'h01;
    bus.flag_we = 1'b1; bus.carry_in = 1'b0;
    #1 rst_n = 1'b0;
    check("midop_reset", 3'd7, 1'b1, 8'h00, 3'd5, 1'b1, 8'h00, 3'b000);
    rst_n = 1'b1;  // write still pending: lands on the next rising edge
    check("post_rst_pre", 3'd7, 1'b1, 8'h00, 3'd3, 1'b1, 8'h00, 3'b000);
    bus.wr_en = 1'b0; bus.flag_we = 1'b0;
    check("post_rst_write", 3'd7, 1'b1, 8'h01, 3'd1, 1'b1, 8'h00, 3'b000);

    // ---- 6. Flag hold under random traffic ------------------------------
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    model[7] = 8'h01;
    bus.wr_data = 8'h80; bus.flag_we = 1'b1; bus.carry_in = 1'b1;
    step();
    bus.flag_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.wr_en    = 1'($urandom);
      bus.wr_addr  = ADDR_W'($urandom);
      bus.wr_data  = DATA_W'($urandom);
      bus.ld_en    = 1'($urandom);
      bus.ld_addr  = ADDR_W'($urandom);
      bus.ld_data  = DATA_W'($urandom);
      bus.carry_in = 1'($urandom);
      ra = ADDR_W'($urandom);
      rb = ADDR_W'($urandom);
      check("flag_hold", ra, 1'b1, model[ra], rb, 1'b1, model[rb], 3'b101);
      if (bus.wr_en) model[bus.wr_addr] = bus.wr_data;
      if (bus.ld_en) model[bus.ld_addr] = bus.ld_data;
    end
    bus.wr_en = 1'b0; bus.ld_en = 1'b0;
    for (int i = 0; i < NUM_REGS / 2; i++) begin
      check("final_contents", ADDR_W'(2*i), 1'b1, model[2*i],
            ADDR_W'(2*i+1), 1'b1, model[2*i+1], 3'b101);
    end

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_regfile.md
Name: alu_operand_regfile

Overview:
Operand register file and status-flag register that sits directly upstream and downstream of the 8-bit ALU. Two asynchronous read ports drive the ALU `a` and `b` operands. One write port takes `alu_out` back, with a status-flag capture taken from `carry_out`. A second write port loads external or immediate data. Together these close the datapath loop of the 8-bit CPU.

Parameters:
- DATA_W, 8, width of each register and of the data ports.
- ADDR_W, 3, width of every register address.
- NUM_REGS, 8, number of implemented registers; must be ≤ 2^ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr_a  input  ADDR_W  read address for operand A.
- rd_data_a  output  DATA_W  operand A to ALU input `a`.
- rd_addr_b  input  ADDR_W  read address for operand B.
- rd_data_b  output  DATA_W  operand B to ALU input `b`.
- wr_en  input  1  write `wr_data` (ALU result) into `wr_addr`.
- wr_addr  input  ADDR_W  result destination.
- wr_data  input  DATA_W  ALU result (`alu_out`).
- ld_en  input  1  write `ld_data` into `ld_addr`.
- ld_addr  input  ADDR_W  load destination.
- ld_data  input  DATA_W  external or immediate load value.
- flag_we  input  1  capture flags from the current result.
- carry_in  input  1  ALU `carry_out`.
- flag_c  output  1  registered carry flag.
- flag_z  output  1  registered zero flag.
- flag_n  output  1  registered negative flag.

Behaviour:
- Reset: when rst_n=0, asynchronously clear all registers to 0 and flag_c, flag_z, flag_n to 0, regardless of clk. Clear any write in flight that cycle. Consequently rd_data_a and rd_data_b read 0 during and after reset.
- Reads are combinational from stored contents. Latency is 0 from address to data.
- No write-to-read bypass. A read of an address being written in the same cycle returns the OLD value, and the new value is visible after the rising edge. This is mandatory: a bypass would form a combinational loop from rd_data through the ALU to wr_data.
- Both read ports are fully independent. rd_addr_a may equal rd_addr_b.
- Writes occur on the rising edge only.
  - wr_en=1: reg[wr_addr] ← wr_data.
  - ld_en=1: reg[ld_addr] ← ld_data.
  - Both enabled, different addresses: both writes occur in the same edge.
  - Both enabled, same address: ld_data wins and wr_data is dropped.
- Out-of-range addresses (addr ≥ NUM_REGS):
  - Writes are ignored with no side effects.
  - Reads return 0.
- Flags update only on a rising edge with flag_we=1:
  - flag_c ← carry_in.
  - flag_z ← (wr_data == 0).
  - flag_n ← wr_data[DATA_W-1].
- Flags are computed from wr_data even when wr_en=0 (compare-style operations) and are independent of ld_en. When flag_we=0, all flags hold.
- Registers and flags hold their value indefinitely when no enable is asserted.
- Reset asserted mid-operation aborts all pending writes. On rst_n deassertion the first write takes effect at the first rising edge with rst_n=1.

Test Plan:
1. Reset and read-back:
   - Stimulus: assert rst_n=0 between edges.
   - Check: all registers read 0 immediately and C/Z/N=0.
   - Stimulus: release reset; ld_en loads R1=0x6F, then R2=0x6F.
   - Check: rd_addr_a=1, rd_addr_b=2 → rd_data_a=0x6F, rd_data_b=0x6F.
2. Result writeback with flags:
   - Stimulus: wr_en=1, wr_addr=3, wr_data=0xDE, flag_we=1, carry_in=0.
   - Check: after the edge R3=0xDE, C=0, Z=0, N=1.
   - Stimulus: next cycle wr_data=0x00, carry_in=1, flag_we=1, wr_en=0.
   - Check: R3 stays 0xDE; C=1, Z=1, N=0.
3. No bypass:
   - Stimulus: R4=0x11; in one cycle rd_addr_a=4 with wr_en=1, wr_addr=4, wr_data=0x22.
   - Check: rd_data_a=0x11 before the edge and 0x22 after it.
4. Write-port collision:
   - Stimulus: ld_en=1, ld_addr=5, ld_data=0xAA and wr_en=1, wr_addr=5, wr_data=0x55 in the same cycle.
   - Check: R5=0xAA.
   - Stimulus: repeat with wr_addr=6.
   - Check: R5=0xAA and R6=0x55.
5. Reset mid-operation:
   - Stimulus: R7=0xFF with flags set; drop rst_n between edges while wr_en=1 targets R7 with 0x01.
   - Check: R7=0 and flags=0 immediately.
   - Stimulus: release reset, then the next edge with wr_en=1 and wr_data=0x01.
   - Check: R7=0x01.
6. Flag hold:
   - Stimulus: set C=1, Z=0, N=1; run 5 cycles with flag_we=0 and random wr_en/ld_en traffic.
   - Check: flags unchanged throughout.
